// File: rtl/addsub_arbiter.sv
// addsub_arbiter
//   Two requesters share one 16-bit ripple adder-subtractor. A grant is
//   issued in IDLE, the winning operands are latched on the accept edge,
//   the sum/difference is computed and registered in EXEC, and the result
//   is presented in RESP until the consumer takes it.
//
// Parameters
//   FIXED_PRIO : 0 = round-robin between contending requesters,
//                1 = requester 0 always wins a contested grant.
//
// Ports
//   clk, rst_n               : clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready  : request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b           : 16-bit operands (A op B)
//   reqN_op                  : 0 = add, 1 = subtract
//   rsp_valid / rsp_ready    : response handshake
//   rsp_s                    : 16-bit sum/difference (wraps modulo 2^16)
//   rsp_c                    : 1 = carry (add) or borrow (subtract)
//   rsp_v                    : signed overflow
//   rsp_id                   : requester that owns the response
//   busy                     : high whenever the FSM is not in IDLE
module addsub_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic        req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_s,
  output logic        rsp_c,
  output logic        rsp_v,
  output logic        rsp_id,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Index of the requester granted on the most recent accepted handshake.
  logic        last_gnt;

  // Grant decision for this cycle (meaningful only when a request is valid).
  logic        gnt_id;
  logic        accept;

  // Operands captured on the accept edge; the request inputs are free to
  // change afterwards without disturbing the operation in flight.
  logic [15:0] lat_a;
  logic [15:0] lat_b;
  logic        lat_op;
  logic        lat_id;

  // Shared adder-subtractor datapath.
  logic [15:0] b_eff;
  logic [15:0] add_s;
  logic [16:0] carry;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  always_comb begin
    gnt_id = 1'b0;
    if (req0_valid && req1_valid) begin
      // Contested: fixed priority favours 0; round-robin favours whoever
      // was not granted last.
      if (FIXED_PRIO != 0) begin
        gnt_id = 1'b0;
      end else begin
        gnt_id = ~last_gnt;
      end
    end else if (req1_valid) begin
      gnt_id = 1'b1;
    end
  end

  // Readys depend only on state, valids and the grant, so they are
  // mutually exclusive by construction.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == IDLE) begin
      req0_ready = req0_valid && (gnt_id == 1'b0);
      req1_ready = req1_valid && (gnt_id == 1'b1);
    end
  end

  assign accept = req0_ready | req1_ready;

  // ---------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // ---------------------------------------------------------------------
  // Ripple adder-subtractor: A + (B xor {16{op}}) + op
  // ---------------------------------------------------------------------
  always_comb begin
    b_eff    = lat_b ^ {16{lat_op}};
    carry    = '0;
    carry[0] = lat_op;
    add_s    = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      add_s[i]   = lat_a[i] ^ b_eff[i] ^ carry[i];
      carry[i+1] = (lat_a[i] & b_eff[i]) | (carry[i] & (lat_a[i] ^ b_eff[i]));
    end
  end

  // ---------------------------------------------------------------------
  // State, grant history, operand latch and result registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;  // requester 0 wins the first contested grant
      lat_a    <= '0;
      lat_b    <= '0;
      lat_op   <= 1'b0;
      lat_id   <= 1'b0;
      rsp_s    <= '0;
      rsp_c    <= 1'b0;
      rsp_v    <= 1'b0;
      rsp_id   <= 1'b0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        last_gnt <= gnt_id;
        lat_id   <= gnt_id;
        if (gnt_id) begin
          lat_a  <= req1_a;
          lat_b  <= req1_b;
          lat_op <= req1_op;
        end else begin
          lat_a  <= req0_a;
          lat_b  <= req0_b;
          lat_op <= req0_op;
        end
      end

      // Result registers load only in EXEC, so they hold through RESP and
      // keep the last result while idle.
      if (state == EXEC) begin
        rsp_s  <= add_s;
        rsp_c  <= carry[16] ^ lat_op;
        rsp_v  <= carry[15] ^ carry[16];
        rsp_id <= lat_id;
      end
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Testbench for addsub_arbiter: a round-robin instance (u_rr) carries the
// directed operations and the scoreboard; a fixed-priority instance (u_fp)
// shares the same stimulus and is observed for its grant order.
module tb_addsub_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_op, req1_op;
  logic        rsp_ready;

  logic        r0_ready0, r0_ready1, r0_rsp_valid, r0_rsp_c, r0_rsp_v, r0_rsp_id, r0_busy;
  logic [15:0] r0_rsp_s;
  logic        p1_ready0, p1_ready1, p1_rsp_valid, p1_rsp_c, p1_rsp_v, p1_rsp_id, p1_busy;
  logic [15:0] p1_rsp_s;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        id;
  } rsp_t;

  rsp_t sb[$];
  logic [1:0] g0[$];
  logic [1:0] g1[$];

  always #5 clk = ~clk;

  addsub_arbiter #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(r0_ready0),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(r0_ready1),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(r0_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(r0_rsp_s), .rsp_c(r0_rsp_c), .rsp_v(r0_rsp_v),
    .rsp_id(r0_rsp_id), .busy(r0_busy)
  );

  addsub_arbiter #(.FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(p1_ready0),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(p1_ready1),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(p1_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(p1_rsp_s), .rsp_c(p1_rsp_c), .rsp_v(p1_rsp_v),
    .rsp_id(p1_rsp_id), .busy(p1_busy)
  );

  // Reference arithmetic written in terms of operand values and signs.
  function automatic rsp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic op, input logic id);
    rsp_t        r;
    logic [16:0] full;
    if (op) begin
      full = {1'b0, a} - {1'b0, b};
      r.c  = (a < b);
      r.v  = (a[15] != b[15]) && (full[15] != a[15]);
    end else begin
      full = {1'b0, a} + {1'b0, b};
      r.c  = full[16];
      r.v  = (a[15] == b[15]) && (full[15] != a[15]);
    end
    r.s  = full[15:0];
    r.id = id;
    return r;
  endfunction

  // Push the expected result whenever the round-robin instance accepts.
  always @(posedge clk) begin
    if (rst_n) begin
      if (req0_valid && r0_ready0) sb.push_back(model(req0_a, req0_b, req0_op, 1'b0));
      if (req1_valid && r0_ready1) sb.push_back(model(req1_a, req1_b, req1_op, 1'b1));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag);
    rsp_t got;
    rsp_t exp;
    got = {r0_rsp_s, r0_rsp_c, r0_rsp_v, r0_rsp_id};
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb observed empty queue expected pending entry", tag);
    end
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      chk({tag, "_sb"}, 32'(got), 32'(exp));
    end
  endtask

  // Called at posedge+1 with the DUT idle and rsp_ready high.
  task automatic run_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                        input logic op, input logic [15:0] es, input logic ec,
                        input logic ev, input string tag);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1;
    chk({tag, "_ready"}, id ? r0_ready1 : r0_ready0, 1);
    chk({tag, "_other_ready"}, id ? r0_ready0 : r0_ready1, 0);
    @(posedge clk); #1;
    // Disturb the request inputs: the latched operation must be unaffected.
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~req0_a; req0_b = ~req0_b; req0_op = ~req0_op;
    req1_a = ~req1_a; req1_b = ~req1_b; req1_op = ~req1_op;
    chk({tag, "_exec_valid"}, r0_rsp_valid, 0);
    chk({tag, "_exec_busy"}, r0_busy, 1);
    @(posedge clk); #1;
    chk({tag, "_lat2_valid"}, r0_rsp_valid, 1);
    check_rsp(tag);
    chk({tag, "_s"}, r0_rsp_s, es);
    chk({tag, "_c"}, r0_rsp_c, ec);
    chk({tag, "_v"}, r0_rsp_v, ev);
    chk({tag, "_id"}, r0_rsp_id, id);
    @(posedge clk); #1;
    chk({tag, "_done_valid"}, r0_rsp_valid, 0);
    chk({tag, "_done_busy"}, r0_busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic both_rr;
    logic both_fp;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = 1'b0;
    req1_a = '0; req1_b = '0; req1_op = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("rst_valid", r0_rsp_valid, 0);
    chk("rst_busy", r0_busy, 0);
    chk("rst_s", r0_rsp_s, 0);
    chk("rst_cvid", {r0_rsp_c, r0_rsp_v, r0_rsp_id}, 0);
    repeat (2) @(posedge clk);
    #1;
    // Release with a request already presented: the first edge accepts it.
    rst_n = 1'b1;
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
    run_op(1'b1, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b1, 1'b0, "sub_borrow");
    run_op(1'b1, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b0, 1'b0, "sub_pos");
    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_carry");
    run_op(1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1, "sub_ovf");

    // Consumer stalls for 5 cycles.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h4321; req0_op = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    chk("hold_valid0", r0_rsp_valid, 1);
    check_rsp("hold");
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", r0_rsp_valid, 1);
      chk("hold_s", r0_rsp_s, 16'h5555);
      chk("hold_id", r0_rsp_id, 0);
      chk("hold_readys", {r0_ready0, r0_ready1}, 0);
      chk("hold_busy", r0_busy, 1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", r0_rsp_valid, 0);
    chk("release_busy", r0_busy, 0);
    chk("idle_retain_s", r0_rsp_s, 16'h5555);

    // Reset pulsed while an operation is in EXEC.
    req1_valid = 1'b1; req1_a = 16'h0010; req1_b = 16'h0001; req1_op = 1'b1;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    chk("mid_busy", r0_busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", r0_rsp_valid, 0);
    chk("mid_rst_busy", r0_busy, 0);
    chk("mid_rst_s", r0_rsp_s, 0);
    chk("mid_rst_cvid", {r0_rsp_c, r0_rsp_v, r0_rsp_id}, 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_valid", r0_rsp_valid, 0);
      chk("post_rst_busy", r0_busy, 0);
    end

    // Both requesters valid continuously.
    req0_valid = 1'b1; req0_a = 16'h0100; req0_b = 16'h0001; req0_op = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h0200; req1_b = 16'h0002; req1_op = 1'b1;
    #1;
    chk("first_contest", {r0_ready0, r0_ready1}, 2'b10);
    both_rr = 1'b0;
    both_fp = 1'b0;
    for (int cyc = 0; cyc < 40 && !(g0.size() >= 4 && g1.size() >= 4); cyc++) begin
      if (r0_ready0 && r0_ready1) both_rr = 1'b1;
      if (p1_ready0 && p1_ready1) both_fp = 1'b1;
      if (r0_ready0) g0.push_back(2'd0);
      else if (r0_ready1) g0.push_back(2'd1);
      if (p1_ready0) g1.push_back(2'd0);
      else if (p1_ready1) g1.push_back(2'd1);
      if (r0_rsp_valid) check_rsp("rr");
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (r0_rsp_valid) check_rsp("drain");
      @(posedge clk); #1;
    end
    chk("sb_empty", sb.size(), 0);
    chk("rr_no_dual_ready", both_rr, 0);
    chk("fp_no_dual_ready", both_fp, 0);
    chk("rr_grant0", (g0.size() > 0) ? g0[0] : 2'bxx, 0);
    chk("rr_grant1", (g0.size() > 1) ? g0[1] : 2'bxx, 1);
    chk("rr_grant2", (g0.size() > 2) ? g0[2] : 2'bxx, 0);
    chk("rr_grant3", (g0.size() > 3) ? g0[3] : 2'bxx, 1);
    chk("fp_grant0", (g1.size() > 0) ? g1[0] : 2'bxx, 0);
    chk("fp_grant1", (g1.size() > 1) ? g1[1] : 2'bxx, 0);
    chk("fp_grant2", (g1.size() > 2) ? g1[2] : 2'bxx, 0);
    // The fixed-priority instance only ever served requester 0: 0x0100+0x0001.
    chk("fp_last_s", p1_rsp_s, 16'h0101);
    chk("fp_last_cvid", {p1_rsp_c, p1_rsp_v, p1_rsp_id}, 0);
    chk("fp_idle", {p1_rsp_valid, p1_busy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
